key_arbiter: RTL

- Front-end controller for the electronic piano's note path.
- Synchronises and debounces the seven raw key inputs, then arbitrates simultaneous presses down to a single active note.
- Drives the one-hot key vector consumed by the 7-segment note decoder and the tone generator.
- Guarantees the downstream decoder only ever sees zero or exactly one asserted bit, so "multi-press blanks display" can no longer occur.

---
 rtl/key_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/key_arbiter.sv
// Piano key front end: 2-flop sync, whole-vector debounce, single-note arbitration.
// Optional SUSTAIN_EN adds a sustain input that holds the last note after all keys release.
module key_arbiter #(
    parameter int unsigned N_KEYS     = 7,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] btn_raw,
`ifdef SUSTAIN_EN
    input  logic              sustain,
`endif
    output logic [N_KEYS-1:0] key_onehot,
    output logic [2:0]        key_idx,
    output logic              key_valid,
    output logic              key_event
);

    localparam int unsigned IDX_W = 3;
    // The cycle that loads a new candidate is the first of its DEB_CYCLES stable cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 2);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [N_KEYS-1:0]  s1;
    logic [N_KEYS-1:0]  s2;
    logic [N_KEYS-1:0]  cand;
    logic [N_KEYS-1:0]  stable;
    logic [N_KEYS-1:0]  prev;
    logic [CNT_W-1:0]   cnt;
    logic [N_KEYS-1:0]  new_press;
    logic [N_KEYS-1:0]  onehot_n;
    logic               event_n;
    logic               release_ok;

    // Lowest note number wins, i.e. the highest set bit index.
    function automatic logic [N_KEYS-1:0] pick_note(input logic [N_KEYS-1:0] v);
        logic [N_KEYS-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (v[i]) begin
                p    = '0;
                p[i] = 1'b1;
            end
        end
        return p;
    endfunction

    function automatic logic [IDX_W-1:0] note_idx(input logic [N_KEYS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (oh[i]) idx = IDX_W'(N_KEYS - i);
        end
        return idx;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            stable <= '0;
            prev   <= '0;
            cnt    <= '0;
        end else begin
            s1   <= btn_raw;
            s2   <= s1;
            prev <= stable;
            // Counter parks at CNT_LAST once the candidate is accepted.
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= cand;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign new_press = stable & ~prev;

`ifdef SUSTAIN_EN
    assign release_ok = ~sustain;
`else
    assign release_ok = 1'b1;
`endif

    always_comb begin
        state_n  = state;
        onehot_n = key_onehot;
        event_n  = 1'b0;
        case (state)
            IDLE: begin
                if (|stable) begin
                    onehot_n = pick_note(stable);
                    state_n  = PLAY;
                    event_n  = 1'b1;
                end
            end
            PLAY: begin
                if (|new_press) begin
                    onehot_n = pick_note(new_press);
                    event_n  = 1'b1;
                end else if (!(|(stable & key_onehot))) begin
                    if (|stable) begin
                        onehot_n = pick_note(stable);
                        event_n  = 1'b1;
                    end else if (release_ok) begin
                        onehot_n = '0;
                        state_n  = IDLE;
                    end
                end
            end
            default: begin
                onehot_n = '0;
                state_n  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            key_onehot <= '0;
            key_idx    <= '0;
            key_valid  <= 1'b0;
            key_event  <= 1'b0;
        end else begin
            state      <= state_n;
            key_onehot <= onehot_n;
            key_idx    <= note_idx(onehot_n);
            key_valid  <= |onehot_n;
            key_event  <= event_n;
        end
    end

endmodule
